// File: rtl/rv32i_types.sv
// ============================================================================
// Module : rv32i_types
// Brief  : Shared core types: CDB result record, source indices, CDB sizing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rob_idx;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        pc_select;
        logic [31:0] pc_branch;
    } cdb_t;

    localparam int SRC_ADD = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;
    localparam int SRC_BR  = 3;
    localparam int SRC_MEM = 4;

    localparam int CDB_NUM_SRC   = 5;
    localparam int CDB_NUM_PORTS = 2;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_multi_pick.sv
// ============================================================================
// Module : rr_multi_pick
// Brief  : Combinational round-robin pick of up to NUM_CDB requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_multi_pick #(
    parameter int NUM_SRC = 5,
    parameter int NUM_CDB = 2,
    parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]              req,
    input  logic [PW-1:0]                   start,
    output logic [NUM_CDB-1:0][NUM_SRC-1:0] grant,
    output logic [PW-1:0]                   last_idx,
    output logic                            any_grant
);

    always_comb begin
        int         cnt;
        logic [PW:0] sum;
        logic [PW-1:0] idx;
        grant     = '0;
        last_idx  = start;
        any_grant = 1'b0;
        cnt       = 0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            // Scan position wraps modulo NUM_SRC starting at the pointer.
            sum = {1'b0, start} + (PW+1)'(off);
            if (sum >= (PW+1)'(NUM_SRC)) begin
                sum = sum - (PW+1)'(NUM_SRC);
            end
            idx = sum[PW-1:0];
            if (req[idx] && (cnt < NUM_CDB)) begin
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cnt == k) begin
                        grant[k][idx] = 1'b1;
                    end
                end
                cnt       = cnt + 1;
                last_idx  = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : Shares NUM_CDB registered broadcast ports among NUM_SRC units.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int NUM_CDB = CDB_NUM_PORTS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               global_branch_signal,
    input  cdb_t               src_cdb [NUM_SRC],
    output logic [NUM_SRC-1:0] src_ready,
    output cdb_t               cdb_out [NUM_CDB],
    output logic [NUM_SRC-1:0] grant_dbg
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]              r_buf_valid;
    cdb_t                            r_buf [NUM_SRC];
    cdb_t                            r_cdb [NUM_CDB];
    logic [NUM_SRC-1:0]              r_grant;
    logic [PW-1:0]                   r_rr_ptr;

    cdb_t                            w_pend [NUM_SRC];
    logic [NUM_SRC-1:0]              w_req;
    logic [NUM_CDB-1:0][NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0]              w_gnt_src;
    logic [PW-1:0]                   w_last;
    logic                            w_any;
    cdb_t                            w_port [NUM_CDB];

    // A held entry always wins over the live input; flush suppresses all requests.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pend[i] = r_buf_valid[i] ? r_buf[i] : src_cdb[i];
            w_req[i]  = (r_buf_valid[i] | src_cdb[i].valid) & ~global_branch_signal;
        end
    end

    rr_multi_pick #(
        .NUM_SRC (NUM_SRC),
        .NUM_CDB (NUM_CDB),
        .PW      (PW)
    ) u_pick (
        .req       (w_req),
        .start     (r_rr_ptr),
        .grant     (w_grant),
        .last_idx  (w_last),
        .any_grant (w_any)
    );

    always_comb begin
        w_gnt_src = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            w_port[k] = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_grant[k][i]) begin
                    w_port[k] = w_pend[i];
                end
            end
            w_gnt_src = w_gnt_src | w_grant[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_buf[i] <= '0;
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                r_cdb[k] <= '0;
            end
        end else if (global_branch_signal) begin
            r_buf_valid <= '0;
            r_grant     <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                r_cdb[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_gnt_src[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end else if (!r_buf_valid[i] && src_cdb[i].valid) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf[i]       <= src_cdb[i];
                end
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                r_cdb[k] <= w_port[k];
            end
            r_grant <= w_gnt_src;
            if (w_any) begin
                r_rr_ptr <= (w_last == PW'(NUM_SRC - 1)) ? '0 : w_last + 1'b1;
            end
        end
    end

    // A unit must not present a result while its previous one is still held.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            assert (rst || !(src_cdb[i].valid && r_buf_valid[i]))
                else $error("cdb_arbiter: source %0d presented while buffer full", i);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_out[k] = global_branch_signal ? '0 : r_cdb[k];
        end
    end

    assign src_ready = ~r_buf_valid;
    assign grant_dbg = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Directed self-checking bench for cdb_arbiter (5 sources, 2 ports).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import rv32i_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       global_branch_signal;
    cdb_t       src_cdb [5];
    logic [4:0] src_ready;
    cdb_t       cdb_out [2];
    logic [4:0] grant_dbg;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.NUM_SRC(5), .NUM_CDB(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .global_branch_signal (global_branch_signal),
        .src_cdb              (src_cdb),
        .src_ready            (src_ready),
        .cdb_out              (cdb_out),
        .grant_dbg            (grant_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic cdb_t mk(input int rob);
        cdb_t r;
        r.valid     = 1'b1;
        r.rob_idx   = 5'(rob);
        r.pd        = 6'(rob + 32);
        r.rd        = 5'(rob + 1);
        r.data      = 32'hA5A5_0000 + 32'(rob);
        r.pc_select = rob[0];
        r.pc_branch = 32'h0000_1000 + 32'(rob * 4);
        return r;
    endfunction

    task automatic idle();
        for (int i = 0; i < 5; i++) src_cdb[i] = '0;
        global_branch_signal = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic all_req(input int base);
        for (int i = 0; i < 5; i++) src_cdb[i] = mk(base + i);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", src_ready, 5'b11111);
        chk("rst_cdb0",  cdb_out[0], '0);
        chk("rst_cdb1",  cdb_out[1], '0);
        chk("rst_grant", grant_dbg, 5'b00000);

        // T1: idle cycles
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t1_ready", src_ready, 5'b11111);
            chk("t1_v0", cdb_out[0].valid, 1'b0);
            chk("t1_v1", cdb_out[1].valid, 1'b0);
        end

        // T2: add + br at rr_ptr 0 -> ports 0/1, ptr becomes 4
        src_cdb[SRC_ADD] = mk(3);
        src_cdb[SRC_BR]  = mk(7);
        tick();
        idle();
        chk("t2_cdb0",  cdb_out[0], mk(3));
        chk("t2_cdb1",  cdb_out[1], mk(7));
        chk("t2_grant", grant_dbg, 5'b01001);
        chk("t2_ready", src_ready, 5'b11111);

        // T4: wrap-around at rr_ptr 4: mem first, then add; ptr becomes 1
        src_cdb[SRC_MEM] = mk(12);
        src_cdb[SRC_ADD] = mk(1);
        tick();
        idle();
        chk("t4_cdb0",  cdb_out[0], mk(12));
        chk("t4_cdb1",  cdb_out[1], mk(1));
        chk("t4_grant", grant_dbg, 5'b10001);

        // ptr 1: mul ahead of add
        src_cdb[SRC_MUL] = mk(20);
        src_cdb[SRC_ADD] = mk(21);
        tick();
        idle();
        chk("t4_ptr1_cdb0", cdb_out[0], mk(20));
        chk("t4_ptr1_cdb1", cdb_out[1], mk(21));

        // mem alone moves ptr back to 0
        src_cdb[SRC_MEM] = mk(22);
        tick();
        idle();
        chk("t4_mem_cdb0", cdb_out[0], mk(22));
        chk("t4_mem_cdb1", cdb_out[1], '0);

        // T3: all five at ptr 0; index 0 = add is the LSB of src_ready
        all_req(24);
        tick();
        idle();
        chk("t3_n1_cdb0",  cdb_out[0], mk(24));
        chk("t3_n1_cdb1",  cdb_out[1], mk(25));
        chk("t3_n1_ready", src_ready, 5'b00011);
        chk("t3_n1_grant", grant_dbg, 5'b00011);
        tick();
        chk("t3_n2_cdb0",  cdb_out[0], mk(26));
        chk("t3_n2_cdb1",  cdb_out[1], mk(27));
        chk("t3_n2_ready", src_ready, 5'b01111);
        tick();
        chk("t3_n3_cdb0",  cdb_out[0], mk(28));
        chk("t3_n3_cdb1",  cdb_out[1], '0);
        chk("t3_n3_ready", src_ready, 5'b11111);

        // T5: buffer div/br/mem, then flush while add requests
        all_req(10);
        tick();
        idle();
        chk("t5_pre_cdb0",  cdb_out[0], mk(10));
        chk("t5_pre_ready", src_ready, 5'b00011);
        global_branch_signal = 1'b1;
        src_cdb[SRC_ADD]     = mk(30);
        #1;
        chk("t5_fl_cdb0", cdb_out[0], '0);
        chk("t5_fl_cdb1", cdb_out[1], '0);
        tick();
        idle();
        chk("t5_n1_cdb0",  cdb_out[0], '0);
        chk("t5_n1_cdb1",  cdb_out[1], '0);
        chk("t5_n1_ready", src_ready, 5'b11111);
        chk("t5_n1_grant", grant_dbg, 5'b00000);
        tick();
        chk("t5_n2_cdb0", cdb_out[0], '0);
        chk("t5_n2_cdb1", cdb_out[1], '0);
        // ptr stayed at 2: br before add
        src_cdb[SRC_ADD] = mk(5);
        src_cdb[SRC_BR]  = mk(6);
        tick();
        idle();
        chk("t5_ptr_cdb0", cdb_out[0], mk(6));
        chk("t5_ptr_cdb1", cdb_out[1], mk(5));

        // T6: ptr 1, all five -> mul/div granted, add/br/mem buffered; then reset
        all_req(15);
        tick();
        idle();
        chk("t6_pre_cdb0",  cdb_out[0], mk(16));
        chk("t6_pre_cdb1",  cdb_out[1], mk(17));
        chk("t6_pre_ready", src_ready, 5'b00110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_ready", src_ready, 5'b11111);
        chk("t6_rst_cdb0",  cdb_out[0], '0);
        chk("t6_rst_cdb1",  cdb_out[1], '0);
        chk("t6_rst_grant", grant_dbg, 5'b00000);
        // ptr back at 0: mul ahead of mem
        src_cdb[SRC_MUL] = mk(9);
        src_cdb[SRC_MEM] = mk(8);
        tick();
        idle();
        chk("t6_post_cdb0",  cdb_out[0], mk(9));
        chk("t6_post_cdb1",  cdb_out[1], mk(8));
        chk("t6_post_grant", grant_dbg, 5'b10010);
        tick();
        chk("t6_idle_cdb0", cdb_out[0], '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
